// File: rtl/screen_dbuf.sv
// Double-buffered 4-bit indexed framebuffer with a 16-entry RGB444 palette.
// Pixel writes land in the back buffer while the front buffer is scanned out.
// A swap request is held until the next frame_start.
//   clk, rst_n              : clock, asynchronous active-low reset
//   info, info_valid        : command word (swap / palette / pixel write)
//   frame_start             : vertical blank pulse, commits a pending swap
//   scan_x, scan_y          : raw scan coordinates
//   color                   : RGB444 pixel, two cycles after scan coordinates
//   front_sel, swap_pending : buffer being displayed, swap waiting
//   drop_count              : saturating count of out-of-window pixel writes
module screen_dbuf #(
   parameter int unsigned COORD_W = 10,
   parameter int unsigned WST     = 76,
   parameter int unsigned HST     = 100,
   parameter int unsigned WIN_W   = 488,
   parameter int unsigned WIN_H   = 280,
   parameter logic [11:0] BORDER  = 12'h000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [31:0]        info,
   input  logic               info_valid,
   input  logic               frame_start,
   input  logic [COORD_W-1:0] scan_x,
   input  logic [COORD_W-1:0] scan_y,
   output logic [11:0]        color,
   output logic               front_sel,
   output logic               swap_pending,
   output logic [15:0]        drop_count
);

   localparam int unsigned DEPTH = WIN_W * WIN_H;
   localparam int unsigned AW    = $clog2(DEPTH);

   typedef enum logic {IDLE, PENDING} state_t;

   state_t        state_q, state_d;
   logic          front_sel_q;
   logic [15:0]   drop_q, drop_d;
   logic [11:0]   pal_q [16];
   logic [3:0]    buf0 [DEPTH];
   logic [3:0]    buf1 [DEPTH];
   logic [3:0]    pix1_q;
   logic          win1_q, v1_q;
   logic [11:0]   color_q;

   logic          swap_req_c, toggle_c, pal_wr_c, pix_wr_c;
   logic          wr_win_c, rd_win_c;
   logic [AW-1:0] waddr_c, raddr_c;
   logic          unused_bits;

   function automatic logic in_win(input int unsigned x, input int unsigned y);
      return (x >= WST) && (x < WST + WIN_W) && (y >= HST) && (y < HST + WIN_H);
   endfunction

   function automatic logic [AW-1:0] addr_of(input int unsigned x, input int unsigned y);
      return AW'((y - HST) * WIN_W + (x - WST));
   endfunction

   // Halved coordinates of the write packet and of the scan position
   int unsigned wx_c, wy_c, sx_c, sy_c;
   always_comb begin
      wx_c     = 32'(info[7+2*COORD_W -: COORD_W] >> 1);
      wy_c     = 32'(info[7+COORD_W -: COORD_W] >> 1);
      sx_c     = 32'(scan_x >> 1);
      sy_c     = 32'(scan_y >> 1);
      wr_win_c = in_win(wx_c, wy_c);
      rd_win_c = in_win(sx_c, sy_c);
      waddr_c  = addr_of(wx_c, wy_c);
      // Out-of-window reads are forced to a legal address; their data is ignored
      raddr_c  = rd_win_c ? addr_of(sx_c, sy_c) : '0;
   end

   assign unused_bits = ^{info, scan_x[0], scan_y[0]};

   // Command decode, drop counter and swap FSM next state
   always_comb begin
      state_d    = state_q;
      toggle_c   = 1'b0;
      drop_d     = drop_q;
      swap_req_c = info_valid & info[31];
      pal_wr_c   = info_valid & info[30];
      pix_wr_c   = info_valid & ~info[30] & wr_win_c;
      if (info_valid && !info[30] && !wr_win_c && drop_q != 16'hFFFF)
         drop_d = drop_q + 16'd1;
      case (state_q)
         IDLE:    if (swap_req_c) state_d = PENDING;
         PENDING: if (frame_start) begin
            toggle_c = 1'b1;
            state_d  = swap_req_c ? PENDING : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Control state, palette and scan pipeline
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         front_sel_q <= 1'b0;
         drop_q      <= '0;
         pix1_q      <= '0;
         win1_q      <= 1'b0;
         v1_q        <= 1'b0;
         color_q     <= 12'h000;
         for (int i = 0; i < 16; i++) pal_q[i] <= {4'(i), 4'(i), 4'(i)};
      end else begin
         state_q     <= state_d;
         front_sel_q <= front_sel_q ^ toggle_c;
         drop_q      <= drop_d;
         if (pal_wr_c) pal_q[info[3:0]] <= info[19:8];
         // Stage 1 reads the buffer selected before any toggle in this cycle
         pix1_q      <= front_sel_q ? buf1[raddr_c] : buf0[raddr_c];
         win1_q      <= rd_win_c;
         v1_q        <= 1'b1;
         color_q     <= (v1_q && win1_q) ? pal_q[pix1_q] : BORDER;
      end
   end

   // Pixel storage, not reset; writes always go to the current back buffer
   always_ff @(posedge clk) begin
      if (pix_wr_c && front_sel_q)  buf0[waddr_c] <= info[3:0];
      if (pix_wr_c && !front_sel_q) buf1[waddr_c] <= info[3:0];
   end

   assign color        = color_q;
   assign front_sel    = front_sel_q;
   assign swap_pending = (state_q == PENDING);
   assign drop_count   = drop_q;

endmodule

// File: tb/tb_screen_dbuf.sv
module tb_screen_dbuf;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] info = '0;
   logic        info_valid = 1'b0;
   logic        frame_start = 1'b0;
   logic [9:0]  scan_x = '0;
   logic [9:0]  scan_y = '0;
   logic [11:0] color;
   logic        front_sel;
   logic        swap_pending;
   logic [15:0] drop_count;

   int total = 0;
   int bad   = 0;

   logic [11:0] exp_q [$];
   logic        scan_chk = 1'b0;
   logic        c1, c2;
   string       name_q [$];

   screen_dbuf dut (
      .clk(clk), .rst_n(rst_n), .info(info), .info_valid(info_valid),
      .frame_start(frame_start), .scan_x(scan_x), .scan_y(scan_y),
      .color(color), .front_sel(front_sel), .swap_pending(swap_pending),
      .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   // Track which cycles carry a checked scan; result is due two edges later
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c1 <= 1'b0;
         c2 <= 1'b0;
      end else begin
         c1 <= scan_chk;
         c2 <= c1;
      end
   end

   // Monitor: pop expected colour and compare
   always @(negedge clk) begin
      if (c2) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL color_unexpected: got %03h, no expected value queued", color);
         end else begin
            logic [11:0] e;
            string n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            if (color !== e) begin
               bad++;
               $display("FAIL %s: color got %03h want %03h", n, color, e);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic send(input logic [31:0] w);
      info = w;
      info_valid = 1'b1;
      tick(1);
      info_valid = 1'b0;
   endtask

   task automatic scan(input string nm, input int rx, input int ry, input logic [11:0] e);
      scan_x = 10'(rx);
      scan_y = 10'(ry);
      exp_q.push_back(e);
      name_q.push_back(nm);
      scan_chk = 1'b1;
      tick(1);
      scan_chk = 1'b0;
   endtask

   function automatic logic [31:0] pix(input int rx, input int ry, input int id);
      return (32'(rx) << 18) | (32'(ry) << 8) | 32'(id);
   endfunction

   initial begin
      // Reset values
      tick(3);
      check("rst_color", 32'(color), 32'h000);
      check("rst_front", 32'(front_sel), 32'd0);
      check("rst_pending", 32'(swap_pending), 32'd0);
      check("rst_drop", 32'(drop_count), 32'd0);
      rst_n = 1'b1;
      tick(2);

      // Palette entry 5 <- info[19:8]; pixel (76,100) id 5 into back buffer 1
      send(32'h4000_F505);
      send(32'h0260_C805);
      check("pix_no_drop", 32'(drop_count), 32'd0);
      // Swap word carries a pixel write at (0,0), which is out of window
      send(32'h8000_0000);
      check("swap_pending_set", 32'(swap_pending), 32'd1);
      check("swap_no_toggle_yet", 32'(front_sel), 32'd0);
      check("swap_word_drop", 32'(drop_count), 32'd1);
      frame_start = 1'b1;
      tick(1);
      frame_start = 1'b0;
      check("front_after_swap", 32'(front_sel), 32'd1);
      check("pending_clear", 32'(swap_pending), 32'd0);
      scan("scan_first_px", 152, 200, 12'h0F5);
      send(32'h400F_5005);
      scan("scan_pal_f50", 152, 200, 12'hF50);
      scan("scan_origin_border", 0, 0, 12'h000);
      scan("scan_left_edge", 150, 200, 12'h000);
      scan("scan_first_px_again", 152, 200, 12'hF50);

      // Window edges on writes
      send(pix(150, 200, 1));
      check("drop_x75", 32'(drop_count), 32'd2);
      send(pix(151, 200, 1));
      check("drop_x75_odd", 32'(drop_count), 32'd3);
      send(pix(152, 760, 1));
      check("drop_y380", 32'(drop_count), 32'd4);
      send(pix(152, 758, 3));
      send(pix(152, 200, 7));
      send(32'h400A_BC07);
      send(32'h4009_9909);
      check("inwin_no_drop", 32'(drop_count), 32'd4);

      // Swap with pixel in same word, then long wait without frame_start
      send(32'h8000_0000 | pix(154, 200, 9));
      tick(1000);
      check("long_pending", 32'(swap_pending), 32'd1);
      check("long_front", 32'(front_sel), 32'd1);
      scan("scan_old_buffer", 152, 200, 12'hF50);

      // Toggle and new request in the same cycle; the write goes to old back buffer
      frame_start = 1'b1;
      send(32'h8000_0000 | pix(156, 200, 2));
      frame_start = 1'b0;
      check("toggle_keep_front", 32'(front_sel), 32'd0);
      check("toggle_keep_pending", 32'(swap_pending), 32'd1);
      check("toggle_drop", 32'(drop_count), 32'd4);
      scan("scan_b0_a", 152, 200, 12'hABC);
      scan("scan_b0_bottom", 152, 758, 12'h333);
      scan("scan_b0_swapword_px", 154, 200, 12'h999);
      scan("scan_b0_toggle_px", 156, 200, 12'h222);

      // Scan issued in the toggle cycle still reads the old buffer
      frame_start = 1'b1;
      scan("scan_inflight_old", 152, 200, 12'hABC);
      frame_start = 1'b0;
      scan("scan_after_toggle", 152, 200, 12'hF50);
      check("front_back_to_1", 32'(front_sel), 32'd1);
      check("pending_done", 32'(swap_pending), 32'd0);

      // Request and frame_start together from IDLE: pending only
      frame_start = 1'b1;
      send(32'hC000_0000);
      frame_start = 1'b0;
      check("idle_both_pending", 32'(swap_pending), 32'd1);
      check("idle_both_front", 32'(front_sel), 32'd1);
      frame_start = 1'b1;
      tick(1);
      frame_start = 1'b0;
      check("idle_both_toggle", 32'(front_sel), 32'd0);

      // Get front_sel=1 with a swap pending, then reset asynchronously
      send(32'hC000_0000);
      frame_start = 1'b1;
      tick(1);
      frame_start = 1'b0;
      send(32'hC000_0000);
      scan("scan_pre_reset", 152, 200, 12'hF50);
      tick(3);
      check("pre_reset_front", 32'(front_sel), 32'd1);
      check("pre_reset_pending", 32'(swap_pending), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("async_color", 32'(color), 32'h000);
      check("async_front", 32'(front_sel), 32'd0);
      check("async_pending", 32'(swap_pending), 32'd0);
      check("async_drop", 32'(drop_count), 32'd0);
      tick(2);
      rst_n = 1'b1;
      tick(1);
      check("post_reset_pending", 32'(swap_pending), 32'd0);
      // Buffer 0 survives reset; palette is back to defaults
      scan("scan_kept_buffer", 152, 200, 12'h777);
      tick(3);

      // Saturating drop counter
      info = pix(150, 200, 0);
      info_valid = 1'b1;
      tick(65534);
      info_valid = 1'b0;
      check("drop_fffe", 32'(drop_count), 32'h0000_FFFE);
      info_valid = 1'b1;
      tick(3);
      info_valid = 1'b0;
      check("drop_saturate", 32'(drop_count), 32'h0000_FFFF);

      tick(3);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: %0d expected colours never seen", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
